// File: rtl/sram_init_loader_if.sv
// sram_init_loader_if: byte-stream handshake and SRAM init-port bundle
interface sram_init_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              init_en;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, init_en, init_we, init_addr, init_data
  );
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, init_en, init_we, init_addr, init_data
  );
endinterface

// File: rtl/sram_init_loader.sv
// sram_init_loader: assembles a little-endian byte stream (or zeros) into SRAM init writes
module sram_init_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               abort,
  sram_init_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    word_count
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, ZERO, DONE} state_t;
  state_t            state, nxt_state;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic [1:0]        byte_idx, nxt_idx;
  logic [DATA_W-1:0] word, nxt_word;
  logic [ADDR_W:0]   nxt_cnt, cnt_inc;
  logic              last, act;
  assign last    = addr == ADDR_W'(DEPTH - 1);
  assign cnt_inc = word_count + (ADDR_W+1)'(word_count != (ADDR_W+1)'(DEPTH));
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_idx   = byte_idx;
    nxt_word  = word;
    nxt_cnt   = word_count;
    case (state)
      IDLE: begin
        if (clear) begin
          nxt_state = ZERO;
          nxt_addr  = '0;
          nxt_cnt   = '0;
        end else if (start) begin
          nxt_state = LOAD;
          nxt_addr  = '0;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_word  = '0;
        end else if (bus.byte_valid && bus.byte_ready) begin
          nxt_word[8*byte_idx +: 8] = bus.byte_data;
          nxt_idx = byte_idx + 2'd1;
          nxt_state = byte_idx == 2'd3 ? WRITE : LOAD;
        end
      end
      WRITE, ZERO: begin
        // the write itself is already on the registered outputs; abort only stops what follows
        if (abort) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_word  = '0;
        end else begin
          nxt_cnt   = cnt_inc;
          nxt_state = last ? DONE : (state == WRITE ? LOAD : ZERO);
          nxt_addr  = last ? addr : addr + ADDR_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end
  assign act = nxt_state inside {LOAD, WRITE, ZERO};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      byte_idx       <= '0;
      word           <= '0;
      word_count     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.init_en    <= 1'b0;
      bus.init_we    <= 1'b0;
      bus.init_addr  <= '0;
      bus.init_data  <= '0;
    end else begin
      state          <= nxt_state;
      addr           <= nxt_addr;
      byte_idx       <= nxt_idx;
      word           <= nxt_word;
      word_count     <= nxt_cnt;
      busy           <= act;
      done           <= nxt_state == DONE;
      bus.byte_ready <= nxt_state == LOAD;
      bus.init_en    <= act;
      bus.init_we    <= nxt_state inside {WRITE, ZERO};
      bus.init_addr  <= act ? nxt_addr : '0;
      bus.init_data  <= nxt_state == WRITE ? nxt_word : '0;
    end
  end
endmodule

// File: doc/sram_init_loader.md
# sram_init_loader

Upstream loader for the 32 x 32-bit synchronous SRAM initialization port. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive addresses 0..31 through `init_en`/`init_we`/`init_addr`/`init_data`. It also provides a zero-fill (clear) mode. It sits between the boot/debug byte source and the SRAM, and signals completion so the core can release the memory for normal operation.

## Interface
- `DEPTH`, 32: number of SRAM entries to load.
- `ADDR_W`, 5: address width; `DEPTH` = 2^`ADDR_W`.
- `DATA_W`, 32: word width; fixed at 4 bytes.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `start`  in  1  pulse; begin byte-stream load. Ignored unless IDLE.
- `clear`  in  1  pulse; begin zero-fill. Ignored unless IDLE.
- `abort`  in  1  return to IDLE from any busy state.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  byte payload.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `init_en`  out  1  to SRAM init enable.
- `init_we`  out  1  to SRAM init write enable.
- `init_addr`  out  ADDR_W  to SRAM init address.
- `init_data`  out  DATA_W  to SRAM init data.
- `busy`  out  1  high in LOAD, WRITE and ZERO.
- `done`  out  1  one-cycle pulse after the last write.
- `word_count`  out  ADDR_W+1  number of words written since the last start or clear (0..DEPTH).

## Operation
- FSM states: IDLE, LOAD, WRITE, ZERO, DONE. All outputs decode from registers only; there is no combinational input-to-output path.
- **IDLE**
  - All outputs are 0.
  - `clear` takes priority over `start` when both are asserted in the same cycle.
  - `start`: go to LOAD; clear `addr`, `byte_idx` and `word_count`.
  - `clear`: go to ZERO; clear `addr` and `word_count`.
- **LOAD**
  - `init_en`=1, `init_we`=0, `byte_ready`=1.
  - A byte transfers on `byte_valid && byte_ready`.
  - The byte is placed at bits [8*`byte_idx`+7 : 8*`byte_idx`]; the first byte lands in [7:0].
  - `byte_idx` increments on each transfer. On the 4th transfer, `byte_idx` wraps to 0 and the state goes to WRITE.
- **WRITE**, exactly one cycle
  - `init_en`=1, `init_we`=1, `init_addr`=`addr`, `init_data`=assembled word, `byte_ready`=0.
  - `word_count` increments.
  - If `addr`==DEPTH-1, go to DONE. Otherwise increment `addr` and return to LOAD.
- **ZERO**
  - `init_en`=1, `init_we`=1, `init_data`=0, `init_addr`=`addr`.
  - `addr` and `word_count` increment every cycle.
  - After the write at `addr`==DEPTH-1, go to DONE.
- **DONE**, one cycle: `done`=1, `init_en`=0, `busy`=0; then go to IDLE.
- **abort** (LOAD, WRITE or ZERO)
  - Next state is IDLE and the partial word is discarded.
  - A WRITE cycle coinciding with `abort` still performs its write.
  - `word_count` holds its value; `done` is not pulsed.
- Bytes offered while IDLE, WRITE, ZERO or DONE are not accepted (`byte_ready`=0).

## Timing
- **Reset:** state=IDLE. `byte_ready`, `init_en`, `init_we`, `busy` and `done` are 0. `init_addr`, `init_data` and `word_count` are 0. The assembly register is cleared.
- **Reset mid-operation** overrides everything: no write is issued in the reset cycle and the next cycle is IDLE.
- `start` or `clear` sampled at edge N: `busy`=1 from cycle N+1.
- **Load:** the minimum per word is 4 byte cycles plus 1 WRITE cycle = 5 cycles. A full 32-word load with back-to-back bytes takes 160 busy cycles, then 1 DONE cycle.
- **Clear:** 32 busy cycles, then 1 DONE cycle.
- The SRAM captures `init_data` at the rising edge that ends the cycle in which `init_we`=1.
- `byte_valid` may drop at any time in LOAD; assembly stalls with no timeout.
- `word_count` saturates at DEPTH and holds until the next `start` or `clear`.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0, `byte_ready`=0, no `init_we`.
- `start`, then bytes 0x00..0x7F streamed back-to-back -> 32 writes with addr k = {4k+3, 4k+2, 4k+1, 4k} (addr 0 = 0x03020100, addr 31 = 0x7F7E7D7C); `done` pulse at cycle 161 after `start`; `word_count`=32.
- `start` with `byte_valid` toggling 1/0 every cycle -> same data as the back-to-back case; `byte_ready` low during WRITE; each WRITE occurs one cycle after the 4th accepted byte.
- `clear` -> `init_we` high for 32 consecutive cycles, addr 0..31, data 0; `done` on the 33rd cycle.
- `start` and `clear` asserted in the same cycle -> ZERO mode is taken; `start` during busy is ignored.
- `abort` after 2 bytes of word 5 -> no write at addr 5; `word_count`=5; `done`=0; a new `start` restarts at addr 0 with `byte_idx`=0.
